// File: rtl/muldiv_pkg.sv
// Shared constants, op/state encodings and op-class helpers for the multiply/divide unit.
// Optional feature macro used by the sequencer: MULDIV_MADD_EN (MADD/MSUB accumulate).
package muldiv_pkg;

    localparam int MULDIV_WIDTH = 32;
    localparam int MULDIV_ITERS = 32;

    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_MADD  = 3'b110,
        OP_MSUB  = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CALC  = 2'd1,
        ST_FIXUP = 2'd2
    } state_e;

    function automatic logic op_is_signed(input op_e op);
        return (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    function automatic logic op_is_div(input op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_shift_core.sv
// Radix-2 datapath: 64-bit working register doing shift/add multiply or restoring divide
// on unsigned magnitudes, one iteration per asserted step.
module muldiv_shift_core
    import muldiv_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      step,
    input  logic                      is_div,
    input  logic [MULDIV_WIDTH-1:0]   a_mag,
    input  logic [MULDIV_WIDTH-1:0]   b_mag,
    output logic [2*MULDIV_WIDTH-1:0] result
);

    logic [2*MULDIV_WIDTH-1:0] work;
    logic [2*MULDIV_WIDTH-1:0] work_next;
    logic [MULDIV_WIDTH-1:0]   operand;
    logic                      mode_div;

    logic [MULDIV_WIDTH:0]     mul_sum;
    logic [MULDIV_WIDTH:0]     rem_shift;
    logic [MULDIV_WIDTH+1:0]   trial;

    // Multiply: work = {partial, multiplier}; divide: work = {remainder, dividend/quotient}.
    always_comb begin
        mul_sum   = {1'b0, work[63:32]} + (work[0] ? {1'b0, operand} : 33'd0);
        rem_shift = {work[63:32], work[31]};
        trial     = {1'b0, rem_shift} - {2'b00, operand};
        work_next = work;
        if (mode_div) begin
            if (!trial[MULDIV_WIDTH+1])
                work_next = {trial[31:0], work[30:0], 1'b1};
            else
                work_next = {rem_shift[31:0], work[30:0], 1'b0};
        end else begin
            work_next = {mul_sum, work[31:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work     <= '0;
            operand  <= '0;
            mode_div <= 1'b0;
        end else if (load) begin
            mode_div <= is_div;
            operand  <= is_div ? b_mag : a_mag;
            work     <= is_div ? {32'd0, a_mag} : {32'd0, b_mag};
        end else if (step) begin
            work <= work_next;
        end
    end

    assign result = work;

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MIPS multiply/divide controller owning HI/LO; raises Stall while a result is pending.
// Optional MADD/MSUB accumulate enabled by defining MULDIV_MADD_EN.
module muldiv_sequencer
    import muldiv_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic [2:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        ReadHiLo,
    output logic [31:0] Hi,
    output logic [31:0] Lo,
    output logic        Busy,
    output logic        Stall,
    output logic [1:0]  dbg_state
);

    localparam logic [4:0] LAST_ITER = 5'(MULDIV_ITERS - 1);

    state_e      state;
    state_e      state_next;
    logic [4:0]  count;
    op_e         op_in;
    op_e         op_q;
    logic        sign_a;
    logic        sign_b;
    logic        b_zero;
    logic        is_calc_op;
    logic        core_load;
    logic        core_step;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [63:0] core_result;
    logic [63:0] prod_fix;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] hi_fix;
    logic [31:0] lo_fix;

    assign op_in = op_e'(Op);

    always_comb begin
        is_calc_op = 1'b0;
        case (op_in)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_calc_op = 1'b1;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MSUB:                   is_calc_op = 1'b1;
`endif
            default:                            is_calc_op = 1'b0;
        endcase
    end

    assign a_neg = op_is_signed(op_in) & A[31];
    assign b_neg = op_is_signed(op_in) & B[31];
    assign a_mag = a_neg ? -A : A;
    assign b_mag = b_neg ? -B : B;

    always_comb begin
        state_next = state;
        core_load  = 1'b0;
        core_step  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (Start && is_calc_op) begin
                    state_next = ST_CALC;
                    core_load  = 1'b1;
                end
            end
            ST_CALC: begin
                core_step = 1'b1;
                if (count == LAST_ITER)
                    state_next = ST_FIXUP;
            end
            ST_FIXUP: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            op_q   <= OP_MULT;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            state <= state_next;
            if (core_load) begin
                count  <= '0;
                op_q   <= op_in;
                sign_a <= a_neg;
                sign_b <= b_neg;
                b_zero <= (B == 32'd0);
            end else if (state == ST_CALC) begin
                count <= count + 5'd1;
            end
        end
    end

    muldiv_shift_core u_core (
        .clk    (Clk),
        .rst    (Reset),
        .load   (core_load),
        .step   (core_step),
        .is_div (op_is_div(op_in)),
        .a_mag  (a_mag),
        .b_mag  (b_mag),
        .result (core_result)
    );

    // Signs are only latched for signed ops, so unsigned results pass through untouched.
    // A zero divisor forces an all-ones quotient; the remainder then already equals A.
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? -core_result : core_result;
        quot_fix = (sign_a ^ sign_b) ? -core_result[31:0] : core_result[31:0];
        if (b_zero)
            quot_fix = 32'hFFFF_FFFF;
        rem_fix  = sign_a ? -core_result[63:32] : core_result[63:32];
        hi_fix   = prod_fix[63:32];
        lo_fix   = prod_fix[31:0];
        case (op_q)
            OP_DIV, OP_DIVU: begin
                hi_fix = rem_fix;
                lo_fix = quot_fix;
            end
`ifdef MULDIV_MADD_EN
            OP_MADD: {hi_fix, lo_fix} = {Hi, Lo} + prod_fix;
            OP_MSUB: {hi_fix, lo_fix} = {Hi, Lo} - prod_fix;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            Hi <= '0;
            Lo <= '0;
        end else if (state == ST_FIXUP) begin
            Hi <= hi_fix;
            Lo <= lo_fix;
        end else if (state == ST_IDLE && Start) begin
            if (op_in == OP_MTHI) Hi <= A;
            if (op_in == OP_MTLO) Lo <= A;
        end
    end

    assign Busy      = (state != ST_IDLE);
    assign Stall     = Busy & (ReadHiLo | Start);
    assign dbg_state = state;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized scoreboard bench for muldiv_sequencer against an arithmetic reference model.
module tb_muldiv_sequencer;
    import muldiv_pkg::*;

    localparam logic [2:0] T_MULT = 3'd0, T_MULTU = 3'd1, T_DIV = 3'd2, T_DIVU = 3'd3;
    localparam logic [2:0] T_MTHI = 3'd4, T_MTLO = 3'd5, T_MADD = 3'd6, T_MSUB = 3'd7;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [2:0]  Op = 3'd0;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        ReadHiLo = 1'b0;
    logic [31:0] Hi;
    logic [31:0] Lo;
    logic        Busy;
    logic        Stall;
    logic [1:0]  dbg_state;

    logic [63:0] exp_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          checks = 0;
    int          errors = 0;
    int          busy_cnt = 0;
    logic        prev_busy = 1'b0;

    muldiv_sequencer dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .Op        (Op),
        .A         (A),
        .B         (B),
        .ReadHiLo  (ReadHiLo),
        .Hi        (Hi),
        .Lo        (Lo),
        .Busy      (Busy),
        .Stall     (Stall),
        .dbg_state (dbg_state)
    );

    // clock / watchdog
    always #5 Clk = ~Clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic, truncating signed division.
    function automatic logic [63:0] ref_model(input logic [2:0] op, input logic [31:0] a,
                                              input logic [31:0] b, input logic [31:0] hi,
                                              input logic [31:0] lo);
        longint          sa, sb, q, m;
        longint unsigned ua, ub, uq, um;
        logic [63:0]     r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        r  = {hi, lo};
        case (op)
            T_MULT:  r = sa * sb;
            T_MULTU: r = ua * ub;
            T_DIV: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end
            end
            T_DIVU: begin
                if (b == 32'd0) r = {a, 32'hFFFF_FFFF};
                else begin
                    uq = ua / ub;
                    um = ua % ub;
                    r  = {um[31:0], uq[31:0]};
                end
            end
            T_MADD:  r = {hi, lo} + sa * sb;
            T_MSUB:  r = {hi, lo} - sa * sb;
            default: r = {hi, lo};
        endcase
        return r;
    endfunction

    function automatic logic is_calc(input logic [2:0] op);
`ifdef MULDIV_MADD_EN
        return op != T_MTHI && op != T_MTLO;
`else
        return op <= T_DIVU;
`endif
    endfunction

    // driver: one op, optionally holding a stray Start while busy
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rhl, input logic junk);
        logic [63:0] r;
        int          n;
        @(negedge Clk);
        Start    = 1'b1;
        Op       = op;
        A        = a;
        B        = b;
        ReadHiLo = rhl;
        if (op == T_MTHI) m_hi = a;
        else if (op == T_MTLO) m_lo = a;
        else if (is_calc(op)) begin
            r = ref_model(op, a, b, m_hi, m_lo);
            {m_hi, m_lo} = r;
            exp_q.push_back(r);
        end
        @(posedge Clk);
        #1;
        Start = 1'b0;
        if (!is_calc(op)) begin
            chk("no_busy", {63'd0, Busy}, 64'd0);
            chk("hilo_direct", {Hi, Lo}, {m_hi, m_lo});
        end else begin
            if (junk) begin
                repeat (3) @(negedge Clk);
                Start = 1'b1;
                Op    = 3'($urandom_range(0, 5));
                A     = $urandom;
                B     = $urandom;
                repeat (4) @(negedge Clk);
                Start = 1'b0;
            end
            n = 0;
            while (Busy && n < 40) begin
                @(negedge Clk);
                n++;
            end
            if (Busy) begin
                errors++;
                checks++;
                $display("FAIL busy_timeout: Busy still %0b after %0d cycles, required 0", Busy, n);
            end
        end
        ReadHiLo = 1'b0;
    endtask

    task automatic reset_mid_op(input logic [31:0] a, input logic [31:0] b);
        @(negedge Clk);
        Start = 1'b1;
        Op    = T_MULTU;
        A     = a;
        B     = b;
        @(posedge Clk);
        #1;
        Start = 1'b0;
        repeat (10) @(posedge Clk);
        #1;
        Reset = 1'b1;
        #1;
        m_hi = '0;
        m_lo = '0;
        chk("rst_mid_busy", {63'd0, Busy}, 64'd0);
        chk("rst_mid_hilo", {Hi, Lo}, 64'd0);
        chk("rst_mid_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
        @(negedge Clk);
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    // scoreboard monitor: per-cycle Stall check, Busy length and result on Busy fall
    always @(negedge Clk) begin
        logic [63:0] e;
        if (Reset) begin
            busy_cnt  = 0;
            prev_busy = 1'b0;
        end else begin
            chk("stall", {63'd0, Stall}, {63'd0, Busy & (ReadHiLo | Start)});
            if (Busy) busy_cnt++;
            if (prev_busy && !Busy) begin
                chk("busy_cycles", 64'(busy_cnt), 64'd33);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got %h with nothing expected", {Hi, Lo});
                end else begin
                    e = exp_q.pop_front();
                    chk("hilo_result", {Hi, Lo}, e);
                end
                busy_cnt = 0;
            end
            prev_busy = Busy;
        end
    end

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1;
        chk("reset_hilo", {Hi, Lo}, 64'd0);
        chk("reset_busy_stall", {62'd0, Busy, Stall}, 64'd0);
        chk("reset_state", {62'd0, dbg_state}, {62'd0, ST_IDLE});
        repeat (2) @(negedge Clk);
        Reset = 1'b0;

        issue(T_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
        issue(T_MULT,  32'hFFFF_FFFD, 32'h0000_0005, 1'b0, 1'b0);
        issue(T_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 1'b1, 1'b0);
        issue(T_DIVU,  32'h0000_0064, 32'h0000_0000, 1'b0, 1'b0);
        issue(T_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue(T_DIV,   32'hFFFF_FFF0, 32'h0000_0000, 1'b0, 1'b0);
        issue(T_MULT,  32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 1'b1);
        reset_mid_op(32'hDEAD_BEEF, 32'h0000_1234);
        issue(T_DIVU,  32'hDEAD_BEEF, 32'h0000_1234, 1'b1, 1'b0);

        issue(T_MTHI, 32'h0000_0000, 32'h0, 1'b0, 1'b0);
        issue(T_MTLO, 32'h0000_0010, 32'h0, 1'b0, 1'b0);
        issue(T_MADD, 32'h0000_0002, 32'h0000_0003, 1'b0, 1'b0);
        issue(T_MSUB, 32'hFFFF_FFFE, 32'h0000_0007, 1'b0, 1'b0);

        for (int i = 0; i < 30; i++) begin
            logic [2:0] op;
            op = 3'($urandom_range(0, 7));
            issue(op, pick_operand(), pick_operand(), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) == 0));
        end

        repeat (3) @(negedge Clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
